// File: rtl/car_l2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : car_l2_pkg
// Description : Shared types and the address decode helper for the L2 bank
//               crossbar. The decode result carries the window hit flag, the
//               mapping mode that matched, and the bank/row of the word.
//               The response-pipe entry type is also defined here.
// Revision    : 1.0 - initial release
// ============================================================================
package car_l2_pkg;

  // Bank index fields are carried at a fixed width so that the types below
  // do not depend on the crossbar parameters. This limits NumBank to 256.
  localparam int unsigned L2IdxW = 8;

  typedef enum logic [0:0] {
    INTERLEAVE = 1'b0,
    NONE_INTER = 1'b1
  } l2_map_mode_e;

  typedef struct packed {
    logic               hit;
    l2_map_mode_e       mode;
    logic [L2IdxW-1:0]  bank;
    logic [63:0]        row;
  } l2_dec_t;

  // One entry of the per-port response pipeline.
  typedef struct packed {
    logic               valid;
    logic               we;
    logic               miss;
    logic [L2IdxW-1:0]  bank;
  } l2_resp_t;

  // Maps a byte address to {hit, mode, bank, row}. The interleaved window
  // spreads consecutive words over the banks. The non-interleaved window
  // fills one bank completely before it moves on to the next.
  function automatic l2_dec_t l2_decode(
    input logic [63:0] addr,
    input logic [63:0] interl_base,
    input logic [63:0] non_base,
    input logic [63:0] mem_size,
    input int unsigned be_bits,
    input int unsigned bank_bits,
    input int unsigned row_bits
  );
    l2_dec_t     d;
    logic [63:0] word;
    d    = '0;
    word = '0;
    if ((addr >= interl_base) && ((addr - interl_base) < mem_size)) begin
      word   = (addr - interl_base) >> be_bits;
      d.hit  = 1'b1;
      d.mode = INTERLEAVE;
      d.bank = L2IdxW'(word & ((64'd1 << bank_bits) - 64'd1));
      d.row  = word >> bank_bits;
    end else if ((addr >= non_base) && ((addr - non_base) < mem_size)) begin
      word   = (addr - non_base) >> be_bits;
      d.hit  = 1'b1;
      d.mode = NONE_INTER;
      d.bank = L2IdxW'(word >> row_bits);
      d.row  = word & ((64'd1 << row_bits) - 64'd1);
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_bank_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_rr_arb
// Description : NumPort-way round-robin arbiter for a single bank.
//               The grant is combinational. The search starts at the pointer.
//               After a grant the pointer moves to winner+1. With no request
//               the pointer holds its value.
// Ports       : clk_i, rst_ni        - clock, async active-low reset
//               req_i  [NumPort]     - requests
//               gnt_o  [NumPort]     - one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module l2_bank_rr_arb #(
  parameter int unsigned NumPort = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumPort-1:0] req_i,
  output logic [NumPort-1:0] gnt_o
);

  localparam int unsigned PtrW = (NumPort > 1) ? $clog2(NumPort) : 1;

  logic [PtrW-1:0] ptr_d, ptr_q;
  logic [PtrW-1:0] idx, winner;
  logic [PtrW:0]   sum;
  logic            found;

  always_comb begin
    gnt_o  = '0;
    winner = ptr_q;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NumPort; i++) begin
      // idx = (ptr + i) mod NumPort, computed without a divider
      sum = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NumPort)) sum = sum - (PtrW+1)'(NumPort);
      idx = sum[PtrW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        winner     = idx;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (winner == PtrW'(NumPort - 1)) ? '0 : winner + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/l2_bank_xbar.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_xbar
// Description : Connects NumPort memory-protocol requesters to NumBank
//               single-port SRAM banks. Each port decodes its address against
//               an interleaved window and a non-interleaved window. Each bank
//               has a round-robin arbiter. Responses come back in order, a
//               fixed BankLatency cycles after the grant. Uncorrectable ECC
//               errors from the banks are collected into a sticky flag and a
//               saturating counter.
// Ports       : clk_i/rst_ni               - clock, async active-low reset
//               port_* (req/gnt/addr/we/be/wdata/rvalid/rdata/err)
//                                          - requester side
//               bank_* (req/we/row/be/wdata/rdata/ecc_err) - SRAM side
//               ecc_clear_i/ecc_error_o/ecc_err_cnt_o       - ECC status
// Revision    : 1.0 - initial release
// ============================================================================
module l2_bank_xbar
  import car_l2_pkg::*;
#(
  parameter int unsigned      NumPort       = 2,
  parameter int unsigned      NumBank       = 4,
  parameter int unsigned      AddrWidth     = 48,
  parameter int unsigned      DataWidth     = 64,
  parameter longint unsigned  L2MemSize     = 64'd1 << 20,
  parameter logic [AddrWidth-1:0] InterlBase    = '0,
  parameter logic [AddrWidth-1:0] NonInterlBase = '0,
  parameter int unsigned      BankLatency   = 1,
  parameter int unsigned      CntWidth      = 16,
  localparam int unsigned     BeWidth       = DataWidth / 8,
  localparam int unsigned     RowWidth      = $clog2(L2MemSize / (NumBank * BeWidth))
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumPort-1:0]             port_req_i,
  output logic [NumPort-1:0]             port_gnt_o,
  input  logic [NumPort*AddrWidth-1:0]   port_addr_i,
  input  logic [NumPort-1:0]             port_we_i,
  input  logic [NumPort*BeWidth-1:0]     port_be_i,
  input  logic [NumPort*DataWidth-1:0]   port_wdata_i,
  output logic [NumPort-1:0]             port_rvalid_o,
  output logic [NumPort*DataWidth-1:0]   port_rdata_o,
  output logic [NumPort-1:0]             port_err_o,
  output logic [NumBank-1:0]             bank_req_o,
  output logic [NumBank-1:0]             bank_we_o,
  output logic [NumBank*RowWidth-1:0]    bank_row_o,
  output logic [NumBank*BeWidth-1:0]     bank_be_o,
  output logic [NumBank*DataWidth-1:0]   bank_wdata_o,
  input  logic [NumBank*DataWidth-1:0]   bank_rdata_i,
  input  logic [NumBank-1:0]             bank_ecc_err_i,
  input  logic                           ecc_clear_i,
  output logic                           ecc_error_o,
  output logic [CntWidth-1:0]            ecc_err_cnt_o
);

  localparam int unsigned BeBits = $clog2(BeWidth);
  localparam int unsigned BankW  = $clog2(NumBank);
  localparam int unsigned PcW    = $clog2(NumBank + 1);
  localparam int unsigned SumW   = CntWidth + PcW;

  l2_dec_t                          dec [NumPort];
  logic [NumPort-1:0]               hit;
  logic                             unused_dec;
  logic [NumBank-1:0][NumPort-1:0]  arb_req, arb_gnt;
  l2_resp_t                         pipe_d [NumPort][BankLatency];
  l2_resp_t                         pipe_q [NumPort][BankLatency];
  logic [NumBank-1:0]               rd_done, ecc_hit;
  logic [PcW-1:0]                   ecc_pop;
  logic [SumW-1:0]                  cnt_sum;
  logic                             ecc_flag_d, ecc_flag_q;
  logic [CntWidth-1:0]              ecc_cnt_d, ecc_cnt_q;

  // Address decode and per-bank request vectors
  always_comb begin
    unused_dec = 1'b0;
    arb_req    = '0;
    hit        = '0;
    for (int p = 0; p < NumPort; p++) begin
      dec[p] = l2_decode(64'(port_addr_i[p*AddrWidth +: AddrWidth]),
                         64'(InterlBase), 64'(NonInterlBase), 64'(L2MemSize),
                         BeBits, BankW, RowWidth);
      hit[p] = dec[p].hit;
      unused_dec = unused_dec ^ (^dec[p]);
      for (int b = 0; b < NumBank; b++) begin
        arb_req[b][p] = port_req_i[p] & dec[p].hit & (dec[p].bank == L2IdxW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBank; b++) begin : g_bank_arb
    l2_bank_rr_arb #(
      .NumPort (NumPort)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (arb_req[b]),
      .gnt_o  (arb_gnt[b])
    );
  end

  // Bank-side muxes (the grants are one-hot per bank) and port grants.
  // A miss is accepted at once, because it never touches a bank.
  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_row_o   = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    port_gnt_o   = port_req_i & ~hit;
    for (int b = 0; b < NumBank; b++) begin
      for (int p = 0; p < NumPort; p++) begin
        if (arb_gnt[b][p]) begin
          port_gnt_o[p]                            = 1'b1;
          bank_req_o[b]                            = 1'b1;
          bank_we_o[b]                             = port_we_i[p];
          bank_row_o[b*RowWidth +: RowWidth]       = dec[p].row[RowWidth-1:0];
          bank_be_o[b*BeWidth +: BeWidth]          = port_be_i[p*BeWidth +: BeWidth];
          bank_wdata_o[b*DataWidth +: DataWidth]   = port_wdata_i[p*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Response shift pipeline. Stage 0 is loaded in the grant cycle, and the
  // last stage lines up with the cycle in which bank data is valid.
  always_comb begin
    for (int p = 0; p < NumPort; p++) begin
      pipe_d[p][0].valid = port_gnt_o[p];
      pipe_d[p][0].we    = port_we_i[p];
      pipe_d[p][0].miss  = ~hit[p];
      pipe_d[p][0].bank  = dec[p].bank;
      for (int s = 1; s < BankLatency; s++) begin
        pipe_d[p][s] = pipe_q[p][s-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPort; p++) begin
        for (int s = 0; s < BankLatency; s++) begin
          pipe_q[p][s] <= '0;
        end
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Response formation. rd_done marks the banks whose output this cycle
  // belongs to a routed read, so ECC flags that come with writes or idle
  // cycles are ignored.
  always_comb begin
    port_rvalid_o = '0;
    port_rdata_o  = '0;
    port_err_o    = '0;
    rd_done       = '0;
    for (int p = 0; p < NumPort; p++) begin
      if (pipe_q[p][BankLatency-1].valid) begin
        port_rvalid_o[p] = 1'b1;
        if (pipe_q[p][BankLatency-1].miss) begin
          port_err_o[p] = 1'b1;
        end else if (!pipe_q[p][BankLatency-1].we) begin
          for (int b = 0; b < NumBank; b++) begin
            if (pipe_q[p][BankLatency-1].bank == L2IdxW'(b)) begin
              rd_done[b]                            = 1'b1;
              port_err_o[p]                         = bank_ecc_err_i[b];
              port_rdata_o[p*DataWidth +: DataWidth] = bank_rdata_i[b*DataWidth +: DataWidth];
            end
          end
        end
      end
    end
  end

  // ECC aggregation. A clear and new errors in the same cycle leave the new
  // errors visible.
  always_comb begin
    ecc_hit = bank_ecc_err_i & rd_done;
    ecc_pop = '0;
    for (int b = 0; b < NumBank; b++) begin
      ecc_pop = ecc_pop + PcW'(ecc_hit[b]);
    end
    cnt_sum    = (ecc_clear_i ? '0 : SumW'(ecc_cnt_q)) + SumW'(ecc_pop);
    ecc_cnt_d  = (cnt_sum > SumW'({CntWidth{1'b1}})) ? '1 : cnt_sum[CntWidth-1:0];
    ecc_flag_d = (~ecc_clear_i & ecc_flag_q) | (|ecc_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ecc_flag_q <= 1'b0;
      ecc_cnt_q  <= '0;
    end else begin
      ecc_flag_q <= ecc_flag_d;
      ecc_cnt_q  <= ecc_cnt_d;
    end
  end

  assign ecc_error_o   = ecc_flag_q;
  assign ecc_err_cnt_o = ecc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_bank_xbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_bank_xbar
// Description : Directed self-checking bench for l2_bank_xbar. The design is
//               set up with 4 ports, 4 banks, BankLatency=2 and CntWidth=2.
//               A behavioural bank model returns a data pattern built from
//               the bank and row, delayed by two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_bank_xbar;

  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int AW  = 48;
  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int RW  = 15;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req, we, gnt, rvalid, err;
  logic [NP*AW-1:0]  addr;
  logic [NP*BW-1:0]  be;
  logic [NP*DW-1:0]  wdata, rdata;
  logic [NB-1:0]     bank_req, bank_we, bank_ecc, ecc_arm;
  logic [NB*RW-1:0]  bank_row;
  logic [NB*BW-1:0]  bank_be;
  logic [NB*DW-1:0]  bank_wdata, bank_rdata;
  logic              ecc_clear, ecc_error;
  logic [CW-1:0]     ecc_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l2_bank_xbar #(
    .NumPort       (NP),
    .NumBank       (NB),
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .L2MemSize     (64'd1 << 20),
    .InterlBase    (48'h0),
    .NonInterlBase (48'h10_0000),
    .BankLatency   (2),
    .CntWidth      (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .port_req_i     (req),
    .port_gnt_o     (gnt),
    .port_addr_i    (addr),
    .port_we_i      (we),
    .port_be_i      (be),
    .port_wdata_i   (wdata),
    .port_rvalid_o  (rvalid),
    .port_rdata_o   (rdata),
    .port_err_o     (err),
    .bank_req_o     (bank_req),
    .bank_we_o      (bank_we),
    .bank_row_o     (bank_row),
    .bank_be_o      (bank_be),
    .bank_wdata_o   (bank_wdata),
    .bank_rdata_i   (bank_rdata),
    .bank_ecc_err_i (bank_ecc),
    .ecc_clear_i    (ecc_clear),
    .ecc_error_o    (ecc_error),
    .ecc_err_cnt_o  (ecc_cnt)
  );

  function automatic logic [63:0] data_of(input int b, input int row);
    return {32'hDA7A_0000 + 32'(b), 32'(row)};
  endfunction

  // Two-cycle bank model. Its ECC flag follows every armed access, including
  // writes.
  logic [NB-1:0]    bm_v0, bm_v1, bm_e0, bm_e1;
  logic [NB*RW-1:0] bm_r0, bm_r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bm_v0 <= '0; bm_v1 <= '0; bm_e0 <= '0; bm_e1 <= '0; bm_r0 <= '0; bm_r1 <= '0;
    end else begin
      bm_v0 <= bank_req;
      bm_e0 <= bank_req & ecc_arm;
      bm_r0 <= bank_row;
      bm_v1 <= bm_v0;
      bm_e1 <= bm_e0;
      bm_r1 <= bm_r0;
    end
  end

  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      if (bm_v1[b]) bank_rdata[b*DW +: DW] = data_of(b, int'(bm_r1[b*RW +: RW]));
    end
    bank_ecc = bm_e1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req     = '0;
    we      = '0;
    ecc_arm = '0;
  endtask

  task automatic drive(input int p, input logic [AW-1:0] a, input logic w);
    req[p]             = 1'b1;
    we[p]              = w;
    addr[p*AW +: AW]   = a;
    be[p*BW +: BW]     = '1;
    wdata[p*DW +: DW]  = {32'hC0DE_0000 + 32'(p), 32'(a)};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    addr = '0; be = '0; wdata = '0; ecc_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gnt",    64'(gnt),       64'h0);
    check_eq("rst_rvalid", 64'(rvalid),    64'h0);
    check_eq("rst_bankreq",64'(bank_req),  64'h0);
    check_eq("rst_eccflag",64'(ecc_error), 64'h0);
    check_eq("rst_ecccnt", 64'(ecc_cnt),   64'h0);
    rst_n = 1'b1;
    step();

    // Read in flight when an async reset pulse arrives -> no response
    drive(0, 48'h18, 1'b0);
    #1 check_eq("midrst_gnt", 64'(gnt), 64'h1);
    step(); idle();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(); check_eq("midrst_rv1", 64'(rvalid), 64'h0);
    step(); check_eq("midrst_rv2", 64'(rvalid), 64'h0);

    // Post-reset interleaved read of 0x18 -> bank 3 row 0, response at +2
    drive(0, 48'h18, 1'b0);
    #1;
    check_eq("rd_gnt",     64'(gnt),            64'h1);
    check_eq("rd_bankreq", 64'(bank_req),       64'h8);
    check_eq("rd_row3",    64'(bank_row[3*RW +: RW]), 64'h0);
    check_eq("rd_we",      64'(bank_we),        64'h0);
    step(); idle();
    #1 check_eq("rd_rv_early", 64'(rvalid), 64'h0);
    step();
    check_eq("rd_rv",    64'(rvalid),       64'h1);
    check_eq("rd_data",  rdata[0 +: DW],    data_of(3, 0));
    check_eq("rd_err",   64'(err),          64'h0);
    step(); check_eq("rd_rv_pulse", 64'(rvalid), 64'h0);

    // Non-interleaved vs interleaved mapping of offset 0x40000.
    // The ECC flag raised on the write must be ignored.
    drive(0, 48'h14_0000, 1'b1);
    ecc_arm = 4'b0010;
    #1;
    check_eq("ni_bankreq", 64'(bank_req),              64'h2);
    check_eq("ni_we",      64'(bank_we),               64'h2);
    check_eq("ni_row1",    64'(bank_row[1*RW +: RW]),  64'h0);
    check_eq("ni_be1",     64'(bank_be[1*BW +: BW]),   64'hFF);
    check_eq("ni_wdata1",  bank_wdata[1*DW +: DW],     64'hC0DE_0000_0014_0000);
    step(); idle();
    drive(1, 48'h4_0000, 1'b1);
    #1;
    check_eq("il_bankreq", 64'(bank_req),              64'h1);
    check_eq("il_row0",    64'(bank_row[0 +: RW]),     64'h2000);
    step(); idle();
    #1;
    check_eq("wr_rv0",    64'(rvalid),        64'h1);
    check_eq("wr_rdata0", rdata[0 +: DW],     64'h0);
    check_eq("wr_err0",   64'(err),           64'h0);
    step();
    check_eq("wr_rv1",    64'(rvalid),        64'h2);
    check_eq("wr_eccflag",64'(ecc_error),     64'h0);
    check_eq("wr_ecccnt", 64'(ecc_cnt),       64'h0);
    step();

    // Ports 0 and 1 both hold requests to bank 2 -> grants 0,1,0,1
    drive(0, 48'h10, 1'b0);
    drive(1, 48'h30, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1 check_eq($sformatf("arb_gnt%0d", k), 64'(gnt), (k % 2 == 1) ? 64'h2 : 64'h1);
      step();
    end
    idle();
    repeat (3) step();

    // Different banks are granted in the same cycle
    drive(2, 48'h0, 1'b0);
    drive(3, 48'h8, 1'b0);
    #1;
    check_eq("par_gnt",     64'(gnt),      64'hC);
    check_eq("par_bankreq", 64'(bank_req), 64'h3);
    step(); idle();
    repeat (3) step();

    // Decode miss on port 1
    drive(1, 48'h30_0000, 1'b0);
    #1;
    check_eq("miss_gnt",     64'(gnt),      64'h2);
    check_eq("miss_bankreq", 64'(bank_req), 64'h0);
    step(); idle();
    #1 check_eq("miss_rv_early", 64'(rvalid), 64'h0);
    step();
    check_eq("miss_rv",    64'(rvalid),       64'h2);
    check_eq("miss_err",   64'(err),          64'h2);
    check_eq("miss_rdata", rdata[1*DW +: DW], 64'h0);
    step();
    check_eq("miss_eccflag", 64'(ecc_error), 64'h0);

    // Three reads with ECC errors
    drive(0, 48'h0,  1'b0);
    drive(1, 48'h28, 1'b0);
    drive(2, 48'h50, 1'b0);
    ecc_arm = 4'b0111;
    #1 check_eq("ecc_gnt", 64'(gnt), 64'h7);
    step(); idle();
    step();
    check_eq("ecc_rv",     64'(rvalid),       64'h7);
    check_eq("ecc_err",    64'(err),          64'h7);
    check_eq("ecc_rdata1", rdata[1*DW +: DW], data_of(1, 1));
    check_eq("ecc_rdata2", rdata[2*DW +: DW], data_of(2, 2));
    step();
    check_eq("ecc_flag3", 64'(ecc_error), 64'h1);
    check_eq("ecc_cnt3",  64'(ecc_cnt),   64'h3);

    // Clear in the same cycle as one new error -> count 1
    drive(3, 48'h18, 1'b0);
    ecc_arm = 4'b1000;
    step(); idle();
    step();
    ecc_clear = 1'b1;
    #1 check_eq("clr_err", 64'(err), 64'h8);
    step();
    ecc_clear = 1'b0;
    check_eq("clr_cnt",  64'(ecc_cnt),   64'h1);
    check_eq("clr_flag", 64'(ecc_error), 64'h1);

    // Five more errors saturate the 2-bit counter
    for (int p = 0; p < NP; p++) drive(p, AW'(p * 8), 1'b0);
    ecc_arm = 4'hF;
    step(); idle();
    drive(0, 48'h0, 1'b0);
    ecc_arm = 4'h1;
    step(); idle();
    step(); step();
    check_eq("sat_cnt",  64'(ecc_cnt),   64'h3);
    check_eq("sat_flag", 64'(ecc_error), 64'h1);
    ecc_clear = 1'b1;
    step();
    ecc_clear = 1'b0;
    check_eq("clr0_cnt",  64'(ecc_cnt),   64'h0);
    check_eq("clr0_flag", 64'(ecc_error), 64'h0);

    // Four ports stream reads to four distinct banks for four cycles
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) begin
        for (int p = 0; p < NP; p++) drive(p, AW'((k * 4 + (p + k) % 4) * 8), 1'b0);
      end
      #1;
      if (k < 4) check_eq($sformatf("tp_gnt%0d", k), 64'(gnt), 64'hF);
      if (k >= 2) begin
        check_eq($sformatf("tp_rv%0d", k), 64'(rvalid), 64'hF);
        for (int p = 0; p < NP; p++) begin
          check_eq($sformatf("tp_data%0d_p%0d", k, p), rdata[p*DW +: DW],
                   data_of((p + k - 2) % 4, k - 2));
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
